// File: rtl/mem_arbiter_rr_pkg.sv
// mem_arbiter_rr_pkg: arbitration mode encodings and index-width helper
package mem_arbiter_rr_pkg;
  localparam int ARB_RR = 0;
  localparam int ARB_FIXED = 1;
  function automatic int clog2(input int n);
    int w;
    for (w = 1; (1 << w) < n; w++);
    return w;
  endfunction
endpackage

// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: requester ports and single-port RAM bus of the arbiter
interface mem_arbiter_rr_if #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [N_PORTS-1:0] req_rd;
  logic [N_PORTS-1:0] req_wr;
  logic [N_PORTS*ADDR_W-1:0] addr;
  logic [N_PORTS*DATA_W-1:0] wdata;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic ram_wren;
  logic [N_PORTS-1:0] grant;
  logic [N_PORTS-1:0] rvalid;
  logic [N_PORTS*DATA_W-1:0] rdata;
  logic busy;
  modport master (output req_rd, req_wr, addr, wdata, ram_q,
                  input ram_addr, ram_din, ram_wren, grant, rvalid, rdata, busy);
  modport slave (input req_rd, req_wr, addr, wdata, ram_q,
                 output ram_addr, ram_din, ram_wren, grant, rvalid, rdata, busy);
endinterface

// File: rtl/mem_arbiter_rr_rr_arbiter.sv
// rr_arbiter: round-robin or fixed-priority winner selection with rotating pointer
module rr_arbiter #(
  parameter int N = 2,
  parameter int IW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [N-1:0] req,
  input  logic mode,
  input  logic adv,
  output logic [N-1:0] gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] ptr;
  logic found;
  int j;
  // first requester at or after the search start, wrapping around
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = (mode ? 0 : int'(ptr)) + k;
      j = j >= N ? j - N : j;
      if (!found && req[j]) begin
        found = 1'b1;
        gnt[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
  // pointer moves just past the port that won, only in round-robin mode
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (adv && !mode) ptr <= int'(idx) == N - 1 ? '0 : idx + 1'b1;
endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-port arbiter sharing one pipelined single-port RAM
module mem_arbiter_rr import mem_arbiter_rr_pkg::*; #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int ARB_MODE = ARB_RR
) (
  input logic clk,
  input logic rst,
  mem_arbiter_rr_if.slave bus
);
  localparam int IW = clog2(N_PORTS);
  logic [N_PORTS-1:0] req, gnt;
  logic [IW-1:0] idx;
  logic adv, wr, rd;
  logic [RD_LAT:0] tv;
  logic [RD_LAT:0][IW-1:0] tp;
  assign req = bus.req_rd | bus.req_wr;
  assign adv = |req;
  assign wr = bus.req_wr[idx];
  assign rd = bus.req_rd[idx] & ~wr;
  assign bus.busy = |tv;
  rr_arbiter #(.N(N_PORTS), .IW(IW)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(req),
    .mode(ARB_MODE == ARB_FIXED),
    .adv(adv),
    .gnt(gnt),
    .idx(idx)
  );
  // winner's access goes onto the RAM bus together with its grant pulse
  always_ff @(posedge clk)
    if (rst) begin
      bus.ram_addr <= '0;
      bus.ram_din <= '0;
      bus.ram_wren <= 1'b0;
      bus.grant <= '0;
    end else begin
      bus.grant <= gnt;
      bus.ram_wren <= adv & wr;
      if (adv) begin
        bus.ram_addr <= bus.addr[int'(idx)*ADDR_W +: ADDR_W];
        bus.ram_din <= bus.wdata[int'(idx)*DATA_W +: DATA_W];
      end
    end
  // read tags travel alongside the RAM latency so the last stage meets ram_q
  always_ff @(posedge clk)
    if (rst) begin
      tv <= '0;
      tp <= '0;
    end else begin
      tv <= {tv[RD_LAT-1:0], adv & rd};
      tp <= {tp[RD_LAT-1:0], idx};
    end
  // emerging tag steers ram_q into its port's held slice and strobes rvalid
  always_ff @(posedge clk)
    if (rst) begin
      bus.rvalid <= '0;
      bus.rdata <= '0;
    end else begin
      bus.rvalid <= tv[RD_LAT] ? N_PORTS'(1) << tp[RD_LAT] : '0;
      if (tv[RD_LAT]) bus.rdata[int'(tp[RD_LAT])*DATA_W +: DATA_W] <= bus.ram_q;
    end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: three arbiter configurations checked against a transaction-level model
module tb_mem_arbiter_rr;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  function automatic int np(input int k);
    return k == 2 ? 4 : 2;
  endfunction
  function automatic int lt(input int k);
    return k == 2 ? 3 : 1;
  endfunction
  function automatic bit fixed_mode(input int k);
    return k == 1;
  endfunction
  logic [3:0] rrd[3], rwr[3];
  logic [31:0] ad[3], wd[3];
  logic [3:0] og[3], orv[3];
  logic ow[3], ob[3];
  logic [7:0] oa[3], odn[3];
  logic [31:0] ord[3];
  mem_arbiter_rr_if #(.N_PORTS(2), .ADDR_W(8), .DATA_W(8)) b0(), b1();
  mem_arbiter_rr_if #(.N_PORTS(4), .ADDR_W(8), .DATA_W(8)) b2();
  mem_arbiter_rr #(.N_PORTS(2), .ADDR_W(8), .DATA_W(8), .RD_LAT(1), .ARB_MODE(0))
    u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  mem_arbiter_rr #(.N_PORTS(2), .ADDR_W(8), .DATA_W(8), .RD_LAT(1), .ARB_MODE(1))
    u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  mem_arbiter_rr #(.N_PORTS(4), .ADDR_W(8), .DATA_W(8), .RD_LAT(3), .ARB_MODE(0))
    u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  assign b0.req_rd = rrd[0][1:0];
  assign b0.req_wr = rwr[0][1:0];
  assign b0.addr = ad[0][15:0];
  assign b0.wdata = wd[0][15:0];
  assign b1.req_rd = rrd[1][1:0];
  assign b1.req_wr = rwr[1][1:0];
  assign b1.addr = ad[1][15:0];
  assign b1.wdata = wd[1][15:0];
  assign b2.req_rd = rrd[2];
  assign b2.req_wr = rwr[2];
  assign b2.addr = ad[2];
  assign b2.wdata = wd[2];
  assign og[0] = {2'b00, b0.grant};
  assign og[1] = {2'b00, b1.grant};
  assign og[2] = b2.grant;
  assign orv[0] = {2'b00, b0.rvalid};
  assign orv[1] = {2'b00, b1.rvalid};
  assign orv[2] = b2.rvalid;
  assign ow[0] = b0.ram_wren;
  assign ow[1] = b1.ram_wren;
  assign ow[2] = b2.ram_wren;
  assign ob[0] = b0.busy;
  assign ob[1] = b1.busy;
  assign ob[2] = b2.busy;
  assign oa[0] = b0.ram_addr;
  assign oa[1] = b1.ram_addr;
  assign oa[2] = b2.ram_addr;
  assign odn[0] = b0.ram_din;
  assign odn[1] = b1.ram_din;
  assign odn[2] = b2.ram_din;
  assign ord[0] = {16'h0, b0.rdata};
  assign ord[1] = {16'h0, b1.rdata};
  assign ord[2] = b2.rdata;
  // RAMs: address and write registered, read data after RD_LAT edges
  logic [7:0] m0[256], m1[256], m2[256];
  logic [7:0] q0, q1;
  logic [7:0] q2p[3];
  always @(posedge clk) begin
    if (b0.ram_wren) m0[b0.ram_addr] <= b0.ram_din;
    q0 <= m0[b0.ram_addr];
    if (b1.ram_wren) m1[b1.ram_addr] <= b1.ram_din;
    q1 <= m1[b1.ram_addr];
    if (b2.ram_wren) m2[b2.ram_addr] <= b2.ram_din;
    q2p[0] <= m2[b2.ram_addr];
    q2p[1] <= q2p[0];
    q2p[2] <= q2p[1];
  end
  assign b0.ram_q = q0;
  assign b1.ram_q = q1;
  assign b2.ram_q = q2p[2];
  // reference model: expected outputs for the coming cycle
  typedef struct {int k; int left; int port; logic [7:0] data;} pend_t;
  pend_t pq[$];
  int ptr[3];
  logic [3:0] eg[3], erv[3];
  logic ew[3], eb[3];
  logic [7:0] ea[3], ed[3];
  logic [31:0] erd[3];
  logic [7:0] mm[3][256];
  task automatic model_step(input int k);
    int w, j;
    if (rst) begin
      ptr[k] = 0;
      eg[k] = '0;
      erv[k] = '0;
      ew[k] = 1'b0;
      eb[k] = 1'b0;
      ea[k] = '0;
      ed[k] = '0;
      erd[k] = '0;
      for (int i = pq.size() - 1; i >= 0; i--) if (pq[i].k == k) pq.delete(i);
      return;
    end
    erv[k] = '0;
    for (int i = pq.size() - 1; i >= 0; i--)
      if (pq[i].k == k) begin
        pq[i].left--;
        if (pq[i].left == 0) begin
          erv[k][pq[i].port] = 1'b1;
          erd[k][pq[i].port*8 +: 8] = pq[i].data;
          pq.delete(i);
        end
      end
    w = -1;
    for (int off = 0; off < np(k); off++) begin
      j = ((fixed_mode(k) ? 0 : ptr[k]) + off) % np(k);
      if (w < 0 && (rrd[k][j] || rwr[k][j])) w = j;
    end
    eg[k] = '0;
    ew[k] = 1'b0;
    if (w >= 0) begin
      eg[k][w] = 1'b1;
      ea[k] = ad[k][w*8 +: 8];
      ed[k] = wd[k][w*8 +: 8];
      if (rwr[k][w]) begin
        ew[k] = 1'b1;
        mm[k][ea[k]] = ed[k];
      end else pq.push_back('{k, lt(k) + 1, w, mm[k][ea[k]]});
      if (!fixed_mode(k)) ptr[k] = (w + 1) % np(k);
    end
    eb[k] = 1'b0;
    foreach (pq[i]) if (pq[i].k == k) eb[k] = 1'b1;
  endtask
`define CHK(tag, o, e) begin total++; assert ((o) === (e)) else begin bad++; $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, k, o, e); end end
  task automatic check(input int k);
    `CHK("grant", og[k], eg[k])
    `CHK("ram_wren", ow[k], ew[k])
    `CHK("ram_addr", oa[k], ea[k])
    `CHK("ram_din", odn[k], ed[k])
    `CHK("rvalid", orv[k], erv[k])
    `CHK("busy", ob[k], eb[k])
    `CHK("rdata", ord[k], erd[k])
  endtask
  task automatic tick();
    for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check(k);
  endtask
  task automatic set_port(input int k, input int p, input logic rd, input logic wr,
                          input logic [7:0] a, input logic [7:0] d);
    rrd[k][p] = rd;
    rwr[k][p] = wr;
    ad[k][p*8 +: 8] = a;
    wd[k][p*8 +: 8] = d;
  endtask
  task automatic clr(input int k);
    rrd[k] = '0;
    rwr[k] = '0;
  endtask
  initial begin
    int r;
    logic seen;
    for (int k = 0; k < 3; k++) begin
      clr(k);
      ad[k] = '0;
      wd[k] = '0;
      for (int a = 0; a < 256; a++) mm[k][a] = '0;
    end
    for (int a = 0; a < 256; a++) begin
      m0[a] = '0;
      m1[a] = '0;
      m2[a] = '0;
    end
    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (og[k] !== '0 || orv[k] !== '0 || ob[k] !== 1'b0 || ow[k] !== 1'b0 ||
          oa[k] !== '0 || odn[k] !== '0 || ord[k] !== '0) begin
        bad++;
        $error("FAIL reset state inst=%0d", k);
      end
    end
    rst = 1'b0;
    tick();
    set_port(0, 0, 1'b0, 1'b1, 8'h12, 8'hA5);
    tick();
    clr(0);
    tick();
    set_port(0, 0, 1'b1, 1'b0, 8'h12, 8'h00);
    tick();
    clr(0);
    seen = 1'b0;
    repeat (3) begin
      tick();
      seen |= b0.rvalid[0];
    end
    total++;
    if (!seen) begin
      bad++;
      $error("FAIL timeout waiting for rvalid[0]");
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_port(0, 0, 1'b1, 1'b0, 8'h12, 8'h00);
    set_port(0, 1, 1'b1, 1'b0, 8'h13, 8'h00);
    set_port(1, 0, 1'b1, 1'b0, 8'h20, 8'h00);
    set_port(1, 1, 1'b1, 1'b0, 8'h21, 8'h00);
    repeat (4) tick();
    clr(0);
    rrd[1][0] = 1'b0;
    repeat (2) tick();
    clr(1);
    repeat (3) tick();
    set_port(0, 1, 1'b1, 1'b1, 8'h05, 8'h3C);
    tick();
    clr(0);
    repeat (3) tick();
    set_port(0, 1, 1'b1, 1'b0, 8'h05, 8'h00);
    tick();
    clr(0);
    repeat (3) tick();
    set_port(0, 0, 1'b1, 1'b0, 8'h12, 8'h00);
    tick();
    clr(0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    for (int p = 3; p >= 1; p--) begin
      clr(2);
      set_port(2, p, 1'b0, 1'b1, 8'(8'h30 + p), 8'(8'hC0 + p));
      tick();
    end
    for (int p = 3; p >= 1; p--) begin
      clr(2);
      set_port(2, p, 1'b1, 1'b0, 8'(8'h30 + p), 8'h00);
      tick();
    end
    clr(2);
    repeat (6) tick();
    repeat (400) begin
      rst = $urandom_range(0, 99) == 0;
      for (int k = 0; k < 3; k++)
        for (int p = 0; p < np(k); p++)
          if (eg[k][p]) begin
            rrd[k][p] = 1'b0;
            rwr[k][p] = 1'b0;
          end else if (!(rrd[k][p] || rwr[k][p]) && $urandom_range(0, 1) == 1) begin
            r = $urandom_range(0, 3);
            set_port(k, p, r != 1, r != 0, 8'($urandom_range(0, 15)), 8'($urandom));
          end
      tick();
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) clr(k);
    repeat (6) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-port arbiter that shares one single-port synchronous RAM (DRAM-style: registered address, q valid RD_LAT cycles after the address is clocked in).
- Generalises the current two-port MemController:
  - any port count, address width and data width;
  - round-robin or fixed-priority mode;
  - pipelined reads, one RAM access per cycle;
  - per-port read-valid strobes and held read data.
- Sits between CPU/debug/IO requesters and the on-chip RAM.

Parameters:
- N_PORTS, 2, number of requesting ports (2..8).
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, cycles from address presented at RAM to ram_q valid (1..3).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_rd  in  N_PORTS  per-port read request, level; held until granted.
- req_wr  in  N_PORTS  per-port write request, level; held until granted.
- addr  in  N_PORTS*ADDR_W  per-port address; port i at bits [i*ADDR_W +: ADDR_W].
- wdata  in  N_PORTS*DATA_W  per-port write data; same packing as addr.
- ram_q  in  DATA_W  RAM read data.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_din  out  DATA_W  registered RAM write data.
- ram_wren  out  1  registered RAM write enable.
- grant  out  N_PORTS  one-hot, one-cycle pulse: that port's access is on the RAM bus this cycle.
- rvalid  out  N_PORTS  one-cycle pulse: rdata slice for that port was just updated.
- rdata  out  N_PORTS*DATA_W  per-port read data; holds until that port's next read completes.
- busy  out  1  high while any read is in flight in the return pipeline.

Behaviour:
- Reset values (rst high at an edge):
  - ram_addr = 0, ram_din = 0, ram_wren = 0;
  - grant = 0, rvalid = 0, rdata = 0, busy = 0;
  - round-robin pointer = 0;
  - return pipeline cleared.
- Arbitration:
  - Each cycle, port i is requesting if req_rd[i] | req_wr[i].
  - The winner is chosen combinationally from the sampled requests.
  - Round-robin mode: search starts at pointer; after a grant to port k, pointer <= (k+1) mod N_PORTS.
  - Fixed mode: lowest index wins; pointer unused.
  - No requests: grant = 0, ram_wren = 0, ram_addr/ram_din hold their previous values.
- Issue (request sampled at edge E):
  - ram_addr, ram_din, ram_wren and grant are all registered at E, so they appear together in the cycle after E.
  - The requester must deassert its request in the cycle grant is high, or it re-enters arbitration in that cycle.
- Read/write conflict: req_rd and req_wr both high on one port is treated as a write; the read is dropped.
- Writes: ram_wren is high for exactly one cycle per granted write. No rvalid is produced.
- Reads:
  - A tag {valid, port index} enters a shift pipeline of depth RD_LAT+1.
  - When a tag emerges, ram_q is captured into that port's rdata slice and rvalid[port] pulses one cycle.
  - Latency, counted from the grant cycle G: rvalid high in cycle G+RD_LAT+1.
  - Throughput: one access per cycle, reads and writes freely interleaved.
- Ordering:
  - A write granted in cycle G is visible to a read granted in cycle G+1 to the same address.
  - Pipeline order is preserved, so rvalid order follows grant order.
- busy: OR of the valid bits in the return pipeline.
- Reset mid-operation: in-flight reads are discarded, no rvalid is produced, rdata is zeroed.
- N_PORTS = 1: the pointer is constant 0 and the arbiter degenerates to pass-through with the same latency.

Decomposition:
- mem_pkg holds ARB_RR = 0, ARB_FIXED = 1, and a clog2 helper function for the port-index width.
- One sub-module, rr_arbiter:
  - ports: clk, rst, req vector, mode, advance strobe;
  - outputs: one-hot grant and encoded index;
  - contains the pointer register.
- The top module owns the RAM output registers, the tag pipeline and the rdata bank.

Test Plan:
- Reset, then port 0 writes 0xA5 @ 0x12, then port 0 reads 0x12:
  - write grant[0] pulse with ram_wren = 1, ram_addr = 0x12, ram_din = 0xA5;
  - read grant in cycle G, rvalid[0] in G+2 (RD_LAT = 1), rdata[0] = 0xA5.
- Round-robin, ports 0 and 1 both hold read requests continuously for 4 cycles: grants alternate 01, 10, 01, 10; rvalid follows the same order, each 2 cycles after its grant.
- ARB_MODE = 1, both ports requesting: port 0 granted every cycle; port 1 granted only after port 0 deasserts.
- Port 1 req_rd and req_wr both high, wdata = 0x3C @ 0x05: ram_wren = 1 with 0x3C; no rvalid[1]; a later read of 0x05 returns 0x3C.
- rst asserted the cycle after a read grant: rvalid stays 0, busy = 0, rdata = 0.
- N_PORTS = 4, RD_LAT = 3, back-to-back reads on ports 3, 2, 1: rvalid pulses 4 cycles after each grant, in order 3, 2, 1, with correct data per slice.
